// File: rtl/y86_data_memory_ctrl.sv
// Y86-64 data memory: byte-addressed, little-endian storage behind a
// ready/valid request port with a configurable access latency.
module y86_data_memory_ctrl #(
   parameter int DATA_W  = 64,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 64,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              write_En,
   input  logic [ADDR_W-1:0] location,
   input  logic [DATA_W-1:0] M_valA,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] m_valM,
   output logic              data_memerror,
   output logic              busy
);

   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [7:0]        r_mem [0:DEPTH-1];
   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic              r_busy;
   logic              r_err;
   logic [DATA_W-1:0] r_valm;

   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_accept;
   logic              w_access;
   logic [ADDR_W:0]   w_end;
   logic              w_err;
   logic [IDX_W-1:0]  w_base;
   logic [DATA_W-1:0] w_rdata;

   assign w_accept = req_valid & r_req_ready;
   // One extra bit keeps a near-max address from wrapping past the check.
   assign w_end    = {1'b0, r_addr} + (ADDR_W + 1)'(BYTES);
   assign w_err    = (w_end > (ADDR_W + 1)'(DEPTH));
   assign w_base   = r_addr[IDX_W-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_access    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = CNT_W'(LATENCY);
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_access    = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (w_accept) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = CNT_W'(LATENCY);
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_rdata = '0;
      for (int b = 0; b < BYTES; b++) begin
         w_rdata[8*b +: 8] = r_mem[w_base + IDX_W'(b)];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_valm      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= (w_state_nxt != S_WAIT);
         r_rsp_valid <= (w_state_nxt == S_RESP);
         r_busy      <= (w_state_nxt == S_WAIT);
         r_err       <= w_access & w_err;
         if (w_accept) begin
            r_we    <= write_En;
            r_addr  <= location;
            r_wdata <= M_valA;
         end
         if (w_access && !r_we) begin
            r_valm <= w_err ? '0 : w_rdata;
         end
      end
   end

   // Storage has no reset; a reset on the access edge suppresses the commit.
   always_ff @(posedge clk) begin
      if (!reset && w_access && r_we && !w_err) begin
         for (int b = 0; b < BYTES; b++) begin
            r_mem[w_base + IDX_W'(b)] <= r_wdata[8*b +: 8];
         end
      end
   end

   assign req_ready     = r_req_ready;
   assign rsp_valid     = r_rsp_valid;
   assign m_valM        = r_valm;
   assign data_memerror = r_err;
   assign busy          = r_busy;

endmodule

// File: tb/tb_y86_data_memory_ctrl.sv
// Randomized bench for y86_data_memory_ctrl against a byte-array reference
// model; a second instance covers DATA_W=32 with zero latency.
module tb_y86_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, write_En, req_ready, rsp_valid, data_memerror, busy;
   logic [63:0] location, M_valA, m_valM;

   logic        b_req_valid, b_write_En, b_req_ready, b_rsp_valid, b_err, b_busy;
   logic [63:0] b_location;
   logic [31:0] b_M_valA, b_m_valM;

   logic [7:0]  ref_mem [0:1023];
   logic [63:0] exp_valM;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   y86_data_memory_ctrl u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .write_En(write_En), .location(location), .M_valA(M_valA),
      .rsp_valid(rsp_valid), .m_valM(m_valM), .data_memerror(data_memerror),
      .busy(busy)
   );

   y86_data_memory_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(64), .LATENCY(0)) u_dut32 (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .write_En(b_write_En), .location(b_location), .M_valA(b_M_valA),
      .rsp_valid(b_rsp_valid), .m_valM(b_m_valM), .data_memerror(b_err),
      .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] ref_rd(input int a);
      logic [63:0] r;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = ref_mem[a + b];
      return r;
   endfunction

   // Apply one request to the 64-bit instance and check its response.
   task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wd);
      int   n;
      logic err;
      @(negedge clk);
      req_valid = 1'b1; write_En = we; location = addr; M_valA = wd;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = 1'b0; write_En = 1'($urandom);
      location = {$urandom, $urandom}; M_valA = {$urandom, $urandom};
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 20);
      chk("latency", 64'(n), 64'd3);
      err = (addr > 64'd1016);
      if (err) begin
         if (!we) exp_valM = 64'd0;
      end else if (we) begin
         for (int b = 0; b < 8; b++) ref_mem[int'(addr) + b] = wd[8*b +: 8];
      end else begin
         exp_valM = ref_rd(int'(addr));
      end
      chk("memerror", {63'd0, data_memerror}, {63'd0, err});
      chk("m_valM", m_valM, exp_valM);
   endtask

   task automatic xact32(input logic we, input logic [63:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_v, input logic exp_e);
      int n;
      @(negedge clk);
      b_req_valid = 1'b1; b_write_En = we; b_location = addr; b_M_valA = wd;
      n = 0;
      while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      b_req_valid = 1'b0; b_location = {$urandom, $urandom}; b_M_valA = $urandom;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!b_rsp_valid && n < 20);
      chk("lat32", 64'(n), 64'd1);
      chk("err32", {63'd0, b_err}, {63'd0, exp_e});
      chk("valM32", {32'd0, b_m_valM}, {32'd0, exp_v});
   endtask

   initial begin
      logic [63:0] q[$];
      logic [63:0] a;
      logic        rdy, acc;
      int          last_acc, pulses;

      reset = 1'b1; req_valid = 1'b0; write_En = 1'b0; location = '0; M_valA = '0;
      b_req_valid = 1'b0; b_write_En = 1'b0; b_location = '0; b_M_valA = '0;
      exp_valM = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_err", {63'd0, data_memerror}, 64'd0);
      chk("rst_valM", m_valM, 64'd0);
      @(negedge clk); reset = 1'b0;

      for (int k = 0; k < 128; k++) xact(1'b1, 64'(8 * k), {$urandom, $urandom});

      xact(1'b1, 64'd0, 64'h1122334455667788);
      xact(1'b0, 64'd0, 64'd0);
      chk("wr_rd0", m_valM, 64'h1122334455667788);
      xact(1'b1, 64'd8, 64'd0);
      xact(1'b0, 64'd1, 64'd0);
      chk("unaligned", m_valM, 64'h0011223344556677);

      xact(1'b0, 64'd1016, 64'd0);
      xact(1'b0, 64'd1017, 64'd0);
      xact(1'b1, 64'd1017, 64'hFFFF_FFFF_FFFF_FFFF);
      xact(1'b0, 64'd1016, 64'd0);
      xact(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
      xact(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);

      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1020));
         xact(1'($urandom), a, {$urandom, $urandom});
      end

      // Backpressure: req_valid held high while location changes every cycle.
      last_acc = -1;
      write_En = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         req_valid = (c < 52);
         location  = 64'($urandom_range(0, 1016));
         rdy = req_ready;
         acc = rdy && req_valid;
         chk("bp_busy", {63'd0, busy}, {63'd0, !rdy});
         @(posedge clk);
         if (acc) begin
            q.push_back(location);
            if (last_acc >= 0) chk("bp_spacing", 64'(c - last_acc), 64'd4);
            last_acc = c;
         end
         #1;
         if (rsp_valid) begin
            chk("bp_lat", 64'(c - last_acc), 64'd3);
            if (q.size() > 0) begin
               a = q.pop_front();
               exp_valM = ref_rd(int'(a));
               chk("bp_data", m_valM, exp_valM);
            end else begin
               chk("bp_spurious", 64'd1, 64'd0);
            end
         end
      end
      chk("bp_drain", 64'(q.size()), 64'd0);

      // Reset while a write waits for its access edge.
      @(negedge clk);
      chk("mid_ready", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; write_En = 1'b1; location = 64'd40; M_valA = 64'hAAAA_AAAA_AAAA_AAAA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mid_busy", {63'd0, busy}, 64'd1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
      chk("mid_rst_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_err", {63'd0, data_memerror}, 64'd0);
      chk("mid_rst_valM", m_valM, 64'd0);
      exp_valM = 64'd0;
      @(negedge clk); reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) pulses++;
      end
      chk("abort_no_rsp", 64'(pulses), 64'd0);
      xact(1'b0, 64'd40, 64'd0);
      xact(1'b0, 64'd36, 64'd0);

      xact32(1'b1, 64'd4, 32'hDEADBEEF, 32'd0, 1'b0);
      xact32(1'b0, 64'd4, 32'd0, 32'hDEADBEEF, 1'b0);
      xact32(1'b1, 64'd2, 32'h0102_0304, 32'hDEADBEEF, 1'b0);
      xact32(1'b0, 64'd4, 32'd0, 32'hDEAD0102, 1'b0);
      xact32(1'b0, 64'd61, 32'd0, 32'd0, 1'b1);
      xact32(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'h5555_5555, 32'd0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/y86_data_memory_ctrl.md
# y86_data_memory_ctrl

Parametrised, byte-addressed, little-endian data memory for the Y86-64 memory stage. It replaces the fixed single-cycle data memory with a request/response controller. The controller has a configurable word width, depth and access latency, performs an overflow-safe bounds check, and uses a ready/valid handshake so the pipeline can stall while an access is in flight. One request is outstanding at a time.

## Interface
Parameters:
- DATA_W, default 64: word width in bits; a multiple of 8. BYTES = DATA_W/8.
- DEPTH, default 1024: memory size in bytes.
- ADDR_W, default 64: address width.
- LATENCY, default 2: wait cycles between acceptance and access; 0 or more.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- write_En  in  1  1 = write, 0 = read; sampled on acceptance.
- location  in  ADDR_W  byte address; sampled on acceptance.
- M_valA  in  DATA_W  write data; sampled on acceptance.
- rsp_valid  out  1  one-cycle response pulse.
- m_valM  out  DATA_W  read data; holds until the next response.
- data_memerror  out  1  out-of-range flag; valid only while rsp_valid is high.
- busy  out  1  request in flight (state WAIT).

## Operation
- Storage is a DEPTH x 8 array. A word at address A occupies bytes A..A+BYTES-1, with the LSB at A. Unaligned addresses are legal.
- A request is accepted when req_valid and req_ready are both high at a clock edge. location, M_valA and write_En are latched on that edge; later changes to the inputs are ignored.
- Bounds check runs on the latched address with ADDR_W+1-bit arithmetic: error = (location + BYTES > DEPTH). Wrap-around can never pass the check.
- Error on write: memory is unchanged.
- Error on read: m_valM = 0.
- In both error cases, data_memerror = 1 alongside rsp_valid.
- Successful write: all BYTES bytes commit on the access edge. m_valM keeps its previous value.
- Successful read: m_valM is loaded with the assembled word on the access edge.
- Memory contents are not affected by reset and power up undefined. The bench preloads memory by hierarchical init or by writes.
- States:
  - IDLE: req_ready=1. On acceptance → WAIT, cnt ← LATENCY.
  - WAIT: req_ready=0, busy=1. If cnt≠0: cnt ← cnt-1. If cnt=0: perform the access → RESP.
  - RESP: rsp_valid=1, req_ready=1. On acceptance → WAIT, cnt ← LATENCY; otherwise → IDLE.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, busy=0, data_memerror=0, m_valM=0, cnt=0.
- Reset during WAIT aborts the request. A pending write is not committed and no response is issued.
- A write to memory and a read of memory never occur on the same edge, because only one request is outstanding.

## Timing
- Accept at edge E0. The access happens at edge E0+LATENCY+1, and rsp_valid is high during the cycle that follows it.
- Minimum request spacing is LATENCY+2 cycles. Back-to-back acceptance during RESP is permitted.
- LATENCY=0: the response is visible 1 edge after acceptance.
- A request held during WAIT is not accepted. The requester must keep req_valid and its fields stable until req_ready is high.
- rsp_valid never stays high for two consecutive cycles without an intervening acceptance.

## Test plan
- Write then read at LATENCY=2: write 0x1122334455667788 at location 0, then read location 0. Required: rsp_valid rises 3 edges after each acceptance, m_valM=0x1122334455667788, data_memerror=0.
- Unaligned little-endian read: after the previous test, write 0 at location 8, then read location 1. Required: m_valM=0x0011223344556677.
- Bounds check with DEPTH=1024:
  - Read at 1016: succeeds.
  - Read at 1017: data_memerror=1, m_valM=0.
  - Write at 1017: data_memerror=1, and bytes 1017..1023 are unchanged.
  - location=0xFFFFFFFFFFFFFFFC: data_memerror=1, with no address wrap.
- Backpressure: hold req_valid high continuously with changing location. Required: req_ready=0 for LATENCY+1 cycles after each accept, only values present on accept edges are used, and responses are spaced LATENCY+2 cycles apart.
- Reset mid-write: accept a write of 0xAAAA… at 40, then assert reset in WAIT. Required: the next read at 40 returns the prior contents, no rsp_valid is issued for the aborted write, and all outputs are at their reset values the cycle after reset.
- LATENCY=0 parameter sweep with DATA_W=32: write 0xDEADBEEF at 4, then read it back. Required: rsp_valid one edge after each accept, m_valM=0xDEADBEEF.
